// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the round scheduler: block/key widths,
// number of rounds, Rcon table, FSM state encoding and GF(2^8) helpers
// used by the key-expansion step.
package aes_pkg;

  localparam int AES_NR      = 10;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_KEY_W   = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_e;

  // Round constant for the key-expansion step that produces round key 'round'.
  function automatic logic [7:0] aes_rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] aes_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // S-box computed as multiplicative inverse (x^254, which maps 0 to 0)
  // followed by the affine transform; avoids a 256-entry constant table.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] pw;
    logic [7:0] inv;
    pw  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      pw  = aes_gf_mul(pw, pw);
      inv = aes_gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-expansion step: next round key from the current round key
// and the Rcon of the round being produced. Purely combinational.
module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  // RotWord/SubWord/Rcon on the last word, then the running XOR chain.
  always_comb begin
    w0 = key_in[127:96];
    w1 = key_in[95:64];
    w2 = key_in[63:32];
    w3 = key_in[31:0];
    t  = {aes_sbox(w3[23:16]), aes_sbox(w3[15:8]),
          aes_sbox(w3[7:0]),   aes_sbox(w3[31:24])} ^ {rcon, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    key_out = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_round_scheduler.sv
// AES-128 round scheduler: accepts a plaintext/key pair, performs the initial
// AddRoundKey, then issues ten rounds to an external round datapath with a
// fixed ROUND_LAT-cycle turnaround, expanding the key one step per round.
// Optional feature: define AES_ROUND_SCHEDULER_ABORT_EN to add an ABORT input
// that drops an in-flight block while in ISSUE or WAIT.
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int ROUND_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [127:0] IN_DATA,
  input  logic [127:0] IN_KEY,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] OUT_DATA,
  output logic         RND_VALID,
  output logic         RND_LAST,
  output logic [127:0] RND_DATA_OUT,
  output logic [127:0] RND_KEY_OUT,
  input  logic [127:0] RND_DATA_IN
`ifdef AES_ROUND_SCHEDULER_ABORT_EN
  ,
  input  logic         ABORT
`endif
);

  aes_state_e   state;
  aes_state_e   state_nxt;
  logic [3:0]   round_cnt;
  logic [3:0]   lat_cnt;
  logic [127:0] rnd_data;
  logic [127:0] rnd_key;
  logic [127:0] out_data;
  logic         accept;
  logic         sample;
  logic         abort_req;
  logic [127:0] key_src;
  logic [7:0]   rcon_sel;
  logic [127:0] key_next;

`ifdef AES_ROUND_SCHEDULER_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  // Next-state logic plus the accept/sample strobes that drive the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (IN_VALID) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nxt = abort_req ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (abort_req) begin
          state_nxt = ST_IDLE;
        end else if (lat_cnt == 4'(ROUND_LAT)) begin
          sample    = 1'b1;
          state_nxt = (round_cnt == 4'(AES_NR)) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        if (OUT_READY) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The expander serves both the first step (from IN_KEY) and later steps.
  always_comb begin
    key_src  = (state == ST_IDLE) ? IN_KEY : rnd_key;
    rcon_sel = (state == ST_IDLE) ? aes_rcon(4'd1) : aes_rcon(round_cnt + 4'd1);
  end

  aes_key_expand_step u_key_step (
    .key_in  (key_src),
    .rcon    (rcon_sel),
    .key_out (key_next)
  );

  // Round state, round key, counters and result. rnd_data/rnd_key only move
  // on accept or on a non-final sample, so they double as the held outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_cnt <= 4'd0;
      lat_cnt   <= 4'd0;
      rnd_data  <= '0;
      rnd_key   <= '0;
      out_data  <= '0;
    end else begin
      if (state == ST_ISSUE)     lat_cnt <= 4'd1;
      else if (state == ST_WAIT) lat_cnt <= lat_cnt + 4'd1;
      if (accept) begin
        rnd_data  <= IN_DATA ^ IN_KEY;
        rnd_key   <= key_next;
        round_cnt <= 4'd1;
      end else if (sample) begin
        if (round_cnt == 4'(AES_NR)) begin
          out_data <= RND_DATA_IN;
        end else begin
          rnd_data  <= RND_DATA_IN;
          rnd_key   <= key_next;
          round_cnt <= round_cnt + 4'd1;
        end
      end
    end
  end

  assign IN_READY     = (state == ST_IDLE);
  assign OUT_VALID    = (state == ST_DONE);
  assign OUT_DATA     = out_data;
  assign RND_VALID    = (state == ST_ISSUE);
  assign RND_LAST     = (state == ST_ISSUE) && (round_cnt == 4'(AES_NR));
  assign RND_DATA_OUT = rnd_data;
  assign RND_KEY_OUT  = rnd_key;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Testbench for aes_round_scheduler: three instances (ROUND_LAT 4, 1, 15)
// driven by behavioural AES round models, with a queue-based scoreboard.
module tb_aes_round_scheduler;

  localparam int LAT [3] = '{4, 1, 15};

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] LK1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] LK2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct {
    int           inst;
    logic [127:0] data;
    logic [127:0] lkey;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] idat [3];
  logic [127:0] ikey [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] od   [3];
  logic         rv   [3];
  logic         rl   [3];
  logic [127:0] rdo  [3];
  logic [127:0] rko  [3];
  logic [127:0] rdi0, rdi1, rdi2;
`ifdef AES_ROUND_SCHEDULER_ABORT_EN
  logic         ab   [3];
`endif

  exp_t         exp_q [$];
  int           n_pass = 0;
  int           n_total = 0;
  int           cyc = 0;
  int           rcnt [3];
  int           acc_cyc [3];
  int           last_issue [3];
  logic         prev_ov [3] = '{1'b0, 1'b0, 1'b0};
  logic [127:0] held [3];
  int           dp_cnt = 0;
  logic [127:0] dp_res = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  aes_round_scheduler #(.ROUND_LAT(4)) u_dut0 (
    .clk(clk), .rst(rst), .IN_VALID(iv[0]), .IN_READY(ir[0]), .IN_DATA(idat[0]),
    .IN_KEY(ikey[0]), .OUT_VALID(ov[0]), .OUT_READY(ordy[0]), .OUT_DATA(od[0]),
    .RND_VALID(rv[0]), .RND_LAST(rl[0]), .RND_DATA_OUT(rdo[0]), .RND_KEY_OUT(rko[0]),
    .RND_DATA_IN(rdi0)
`ifdef AES_ROUND_SCHEDULER_ABORT_EN
    , .ABORT(ab[0])
`endif
  );

  aes_round_scheduler #(.ROUND_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .IN_VALID(iv[1]), .IN_READY(ir[1]), .IN_DATA(idat[1]),
    .IN_KEY(ikey[1]), .OUT_VALID(ov[1]), .OUT_READY(ordy[1]), .OUT_DATA(od[1]),
    .RND_VALID(rv[1]), .RND_LAST(rl[1]), .RND_DATA_OUT(rdo[1]), .RND_KEY_OUT(rko[1]),
    .RND_DATA_IN(rdi1)
`ifdef AES_ROUND_SCHEDULER_ABORT_EN
    , .ABORT(ab[1])
`endif
  );

  aes_round_scheduler #(.ROUND_LAT(15)) u_dut2 (
    .clk(clk), .rst(rst), .IN_VALID(iv[2]), .IN_READY(ir[2]), .IN_DATA(idat[2]),
    .IN_KEY(ikey[2]), .OUT_VALID(ov[2]), .OUT_READY(ordy[2]), .OUT_DATA(od[2]),
    .RND_VALID(rv[2]), .RND_LAST(rl[2]), .RND_DATA_OUT(rdo[2]), .RND_KEY_OUT(rko[2]),
    .RND_DATA_IN(rdi2)
`ifdef AES_ROUND_SCHEDULER_ABORT_EN
    , .ABORT(ab[2])
`endif
  );

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
  function automatic logic [127:0] tb_round(input logic [127:0] s, input logic [127:0] k,
                                            input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = tb_sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[4*c+rr] = b[4*((c+rr)%4)+rr];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic int find_idx(input int i);
    for (int j = 0; j < exp_q.size(); j++)
      if (exp_q[j].inst == i) return j;
    return -1;
  endfunction

  task automatic flush(input int i);
    int idx;
    idx = find_idx(i);
    while (idx >= 0) begin
      exp_q.delete(idx);
      idx = find_idx(i);
    end
  endtask

  // Round datapath models. Instance 0 presents the true result only on the
  // cycle the scheduler should sample it and random data otherwise.
  always @(negedge clk) begin
    rdi0 = rnd128();
    if (dp_cnt > 0) begin
      dp_cnt--;
      if (dp_cnt == 0) rdi0 = dp_res;
    end
    if (rv[0] === 1'b1) begin
      dp_res = tb_round(rdo[0], rko[0], rl[0]);
      dp_cnt = LAT[0];
    end
    if (rv[1] === 1'b1) rdi1 = tb_round(rdo[1], rko[1], rl[1]);
    if (rv[2] === 1'b1) rdi2 = tb_round(rdo[2], rko[2], rl[2]);
  end

  // Monitor: round issue timing/RND_LAST/round-10 key, and output scoreboard.
  always @(negedge clk) begin : mon
    int idx;
    for (int i = 0; i < 3; i++) begin
      if (rv[i] === 1'b1) begin
        rcnt[i]++;
        if (rcnt[i] == 1) chk("rnd1_cycle", 128'(cyc), 128'(acc_cyc[i] + 1));
        else              chk("rnd_spacing", 128'(cyc - last_issue[i]), 128'(LAT[i] + 1));
        last_issue[i] = cyc;
        chk("rnd_last", 128'(rl[i]), 128'(rcnt[i] == 10));
        if (rl[i] === 1'b1) begin
          idx = find_idx(i);
          if (idx >= 0) chk("rnd10_key", rko[i], exp_q[idx].lkey);
        end
      end
      if (ov[i] === 1'b1) begin
        chk("in_ready_busy", 128'(ir[i]), 128'(0));
        if (!prev_ov[i]) begin
          idx = find_idx(i);
          if (idx < 0) begin
            chk("unexpected_out", 128'(1), 128'(0));
          end else begin
            chk("out_data", od[i], exp_q[idx].data);
            chk("out_cycle", 128'(cyc), 128'(exp_q[idx].due));
            exp_q.delete(idx);
          end
          held[i] = od[i];
        end else begin
          chk("out_hold", od[i], held[i]);
        end
      end
      prev_ov[i] = (ov[i] === 1'b1);
    end
  end

  task automatic send(input int i, input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] ct, input logic [127:0] lk);
    exp_t e;
    int   guard;
    @(negedge clk);
    idat[i] = pt;
    ikey[i] = key;
    iv[i]   = 1'b1;
    guard   = 0;
    while (ir[i] !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (ir[i] !== 1'b1) begin
      chk("accept_timeout", 128'(0), 128'(1));
    end else begin
      e.inst = i; e.data = ct; e.lkey = lk; e.due = cyc + 10*(LAT[i] + 1) + 1;
      exp_q.push_back(e);
      rcnt[i]    = 0;
      acc_cyc[i] = cyc;
    end
    @(negedge clk);
    iv[i]   = 1'b0;
    idat[i] = rnd128();
    ikey[i] = rnd128();
  endtask

  task automatic wait_done(input int i);
    int guard;
    guard = 0;
    while ((find_idx(i) >= 0 || ir[i] !== 1'b1) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk("done_timeout", 128'(guard < 400), 128'(1));
  endtask

  // Returns at the negedge of the n-th RND_VALID cycle of instance 0,
  // counting the current cycle.
  task automatic wait_issue(input int n);
    int seen;
    int guard;
    seen  = 0;
    guard = 0;
    while (guard < 300) begin
      if (rv[0] === 1'b1) seen++;
      if (seen == n) break;
      @(negedge clk);
      guard++;
    end
    if (seen != n) chk("issue_timeout", 128'(seen), 128'(n));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "testbench watchdog expired");
  end

  initial begin : stim
    int guard;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; idat[i] = '0; ikey[i] = '0;
      rcnt[i] = 0; acc_cyc[i] = 0; last_issue[i] = 0; held[i] = '0;
`ifdef AES_ROUND_SCHEDULER_ABORT_EN
      ab[i] = 1'b0;
`endif
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(ir[0]), 128'(1));
    chk("rst_out_valid", 128'(ov[0]), 128'(0));
    chk("rst_rnd_valid", 128'(rv[0]), 128'(0));
    chk("rst_rnd_last", 128'(rl[0]), 128'(0));
    chk("rst_out_data", od[0], 128'(0));
    chk("rst_rnd_data", rdo[0], 128'(0));
    chk("rst_rnd_key", rko[0], 128'(0));
    rst = 1'b0;

    // FIPS-197 C.1 and Appendix B vectors at the default latency.
    send(0, P1, K1, C1, LK1);
    wait_done(0);
    send(0, P2, K2, C2, LK2);
    wait_done(0);

    // Consumer back-pressure: hold for 20 cycles with IN_VALID pulses.
    ordy[0] = 1'b0;
    send(0, P2, K2, C2, LK2);
    guard = 0;
    while (ov[0] !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("hold_out_valid", 128'(ov[0]), 128'(1));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      iv[0]   = (k % 4 == 1);
      idat[0] = rnd128();
      ikey[0] = rnd128();
    end
    @(negedge clk);
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("hold_release_in_ready", 128'(ir[0]), 128'(1));
    chk("hold_release_out_valid", 128'(ov[0]), 128'(0));

    // Reset during WAIT of round 5 discards the block.
    send(0, P1, K1, C1, LK1);
    wait_issue(5);
    @(negedge clk);
    rst = 1'b1;
    flush(0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 128'(ir[0]), 128'(1));
    chk("midrst_out_valid", 128'(ov[0]), 128'(0));
    chk("midrst_rnd_valid", 128'(rv[0]), 128'(0));
    chk("midrst_out_data", od[0], 128'(0));
    send(0, P2, K2, C2, LK2);
    wait_done(0);

`ifdef AES_ROUND_SCHEDULER_ABORT_EN
    // ABORT during the round-3 issue cycle.
    send(0, P1, K1, C1, LK1);
    wait_issue(3);
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    chk("abort_in_ready", 128'(ir[0]), 128'(1));
    chk("abort_out_valid", 128'(ov[0]), 128'(0));
    flush(0);
    send(0, P1, K1, C1, LK1);
    wait_done(0);
`endif

    // Latency extremes.
    send(1, P1, K1, C1, LK1);
    send(2, P1, K1, C1, LK1);
    wait_done(1);
    wait_done(2);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
